// File: rtl/hv_pkg.sv
// hv_pkg: shared constants and types for the hv_core RV32I-subset core.
//   - RV32I opcode / funct3 / funct7 field values used by the decoder
//   - core FSM state enum and ALU operation enum
package hv_pkg;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    localparam logic [2:0] F3Add  = 3'b000;
    localparam logic [2:0] F3Sll  = 3'b001;
    localparam logic [2:0] F3Slt  = 3'b010;
    localparam logic [2:0] F3Sltu = 3'b011;
    localparam logic [2:0] F3Xor  = 3'b100;
    localparam logic [2:0] F3Sr   = 3'b101;
    localparam logic [2:0] F3Or   = 3'b110;
    localparam logic [2:0] F3And  = 3'b111;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    localparam logic [2:0] F3Word = 3'b010;
    localparam logic [2:0] F3Jalr = 3'b000;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StLwait} state_e;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu,
        AluXor, AluSrl, AluSra, AluOr, AluAnd
    } alu_op_e;

endpackage

// File: rtl/hv_if.sv
// hv_if: instruction-fetch and data-memory bus of hv_core.
//   instr_*      : read-only instruction port (request/address out, word + valid in)
//   dmem_*       : word-wide data port (request/write/address/data out, read data + valid in)
// master = core side, slave = memory side.
interface hv_if;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic [31:0] instr_addr_o;
    logic        imem_en_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_rdata_valid_i;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_en_o;
    logic        dmem_wr_o;

    modport master (
        input  instr_i, instr_valid_i, dmem_rdata_i, dmem_rdata_valid_i,
        output instr_addr_o, imem_en_o, dmem_addr_o, dmem_wdata_o, dmem_en_o, dmem_wr_o
    );

    modport slave (
        output instr_i, instr_valid_i, dmem_rdata_i, dmem_rdata_valid_i,
        input  instr_addr_o, imem_en_o, dmem_addr_o, dmem_wdata_o, dmem_en_o, dmem_wr_o
    );
endinterface

// File: rtl/hv_alu.sv
// hv_alu: combinational 32-bit ALU of hv_core.
//   a, b   : operands
//   op     : operation select
//   result : op(a, b), wrap-around, shift amount = b[4:0]
//   eq/lt/ltu : a == b, signed a < b, unsigned a < b (branch compare)
module hv_alu
    import hv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        result = a + b;
        case (op)
            AluAdd:  result = a + b;
            AluSub:  result = a - b;
            AluSll:  result = a << b[4:0];
            AluSlt:  result = {31'b0, lt};
            AluSltu: result = {31'b0, ltu};
            AluXor:  result = a ^ b;
            AluSrl:  result = a >> b[4:0];
            AluSra:  result = $unsigned($signed(a) >>> b[4:0]);
            AluOr:   result = a | b;
            AluAnd:  result = a & b;
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/hv_core.sv
// hv_core: multicycle RV32I-subset core, one instruction at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hv_if.master (instruction fetch + data memory ports)
// Sequence: IDLE -> FETCH -> EXEC -> FETCH (ALU/branch/jump/NOP),
//           EXEC -> MEM -> FETCH (SW), EXEC -> MEM -> LWAIT -> FETCH (LW).
// All bus outputs are registered; unsupported encodings retire as NOPs.
module hv_core
    import hv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic  clk,
    input logic  rst_n,
    hv_if.master bus
);

    state_e      state_q;
    logic [31:0] pc_q, ir_q;
    logic [31:0] rf_q [32];
    logic        imem_en_q, dmem_en_q, dmem_wr_q;
    logic [31:0] instr_addr_q, dmem_addr_q, dmem_wdata_q;

    // Instruction fields
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;

    logic [31:0] alu_a, alu_b, alu_result;
    alu_op_e     alu_op;
    logic        alu_eq, alu_lt, alu_ltu;

    hv_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .eq     (alu_eq),
        .lt     (alu_lt),
        .ltu    (alu_ltu)
    );

    // Decode / execute
    logic        wb_en, is_mem, is_store, taken;
    logic [31:0] wb_val, next_pc;

    always_comb begin
        alu_a    = rs1_val;
        alu_b    = rs2_val;
        alu_op   = AluAdd;
        wb_en    = 1'b0;
        wb_val   = alu_result;
        next_pc  = pc_plus4;
        is_mem   = 1'b0;
        is_store = 1'b0;
        taken    = 1'b0;
        case (opcode)
            OpcLui: begin
                wb_en  = 1'b1;
                wb_val = imm_u;
            end
            OpcAuipc: begin
                wb_en  = 1'b1;
                wb_val = pc_q + imm_u;
            end
            OpcJal: begin
                wb_en   = 1'b1;
                wb_val  = pc_plus4;
                next_pc = pc_q + imm_j;
            end
            OpcJalr: if (funct3 == F3Jalr) begin
                alu_b   = imm_i;
                wb_en   = 1'b1;
                wb_val  = pc_plus4;
                next_pc = alu_result & 32'hFFFF_FFFE;
            end
            OpcBranch: begin
                case (funct3)
                    F3Beq:   taken = alu_eq;
                    F3Bne:   taken = !alu_eq;
                    F3Blt:   taken = alu_lt;
                    F3Bge:   taken = !alu_lt;
                    F3Bltu:  taken = alu_ltu;
                    F3Bgeu:  taken = !alu_ltu;
                    default: taken = 1'b0;
                endcase
                if (taken) next_pc = pc_q + imm_b;
            end
            // Address goes through the ALU adder; only word accesses are supported.
            OpcLoad: if (funct3 == F3Word) begin
                alu_b  = imm_i;
                is_mem = 1'b1;
            end
            OpcStore: if (funct3 == F3Word) begin
                alu_b    = imm_s;
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OpcOpImm: begin
                alu_b = imm_i;
                wb_en = 1'b1;
                case (funct3)
                    F3Add:  alu_op = AluAdd;
                    F3Slt:  alu_op = AluSlt;
                    F3Sltu: alu_op = AluSltu;
                    F3Xor:  alu_op = AluXor;
                    F3Or:   alu_op = AluOr;
                    F3And:  alu_op = AluAnd;
                    F3Sll: begin
                        alu_op = AluSll;
                        wb_en  = (funct7 == F7Base);
                    end
                    default: begin
                        alu_op = (funct7 == F7Alt) ? AluSra : AluSrl;
                        wb_en  = (funct7 == F7Base) || (funct7 == F7Alt);
                    end
                endcase
            end
            OpcOp: begin
                wb_en = 1'b1;
                case ({funct7, funct3})
                    {F7Base, F3Add}:  alu_op = AluAdd;
                    {F7Alt,  F3Add}:  alu_op = AluSub;
                    {F7Base, F3Sll}:  alu_op = AluSll;
                    {F7Base, F3Slt}:  alu_op = AluSlt;
                    {F7Base, F3Sltu}: alu_op = AluSltu;
                    {F7Base, F3Xor}:  alu_op = AluXor;
                    {F7Base, F3Sr}:   alu_op = AluSrl;
                    {F7Alt,  F3Sr}:   alu_op = AluSra;
                    {F7Base, F3Or}:   alu_op = AluOr;
                    {F7Base, F3And}:  alu_op = AluAnd;
                    default:          wb_en  = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // FSM, register file and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
            imem_en_q    <= 1'b0;
            instr_addr_q <= '0;
            dmem_en_q    <= 1'b0;
            dmem_wr_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q      <= StFetch;
                    imem_en_q    <= 1'b1;
                    instr_addr_q <= pc_q;
                end
                StFetch: if (bus.instr_valid_i) begin
                    ir_q      <= bus.instr_i;
                    imem_en_q <= 1'b0;
                    state_q   <= StExec;
                end
                StExec: begin
                    if (is_mem) begin
                        state_q     <= StMem;
                        dmem_en_q   <= 1'b1;
                        dmem_wr_q   <= is_store;
                        dmem_addr_q <= {alu_result[31:2], 2'b00};
                        if (is_store) dmem_wdata_q <= rs2_val;
                    end else begin
                        if (wb_en && rd != 5'd0) rf_q[rd] <= wb_val;
                        pc_q         <= next_pc;
                        instr_addr_q <= next_pc;
                        imem_en_q    <= 1'b1;
                        state_q      <= StFetch;
                    end
                end
                StMem: begin
                    if (dmem_wr_q) begin
                        dmem_en_q    <= 1'b0;
                        dmem_wr_q    <= 1'b0;
                        pc_q         <= pc_plus4;
                        instr_addr_q <= pc_plus4;
                        imem_en_q    <= 1'b1;
                        state_q      <= StFetch;
                    end else begin
                        state_q <= StLwait;
                    end
                end
                StLwait: if (bus.dmem_rdata_valid_i) begin
                    if (rd != 5'd0) rf_q[rd] <= bus.dmem_rdata_i;
                    dmem_en_q    <= 1'b0;
                    pc_q         <= pc_plus4;
                    instr_addr_q <= pc_plus4;
                    imem_en_q    <= 1'b1;
                    state_q      <= StFetch;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.imem_en_o    = imem_en_q;
    assign bus.instr_addr_o = instr_addr_q;
    assign bus.dmem_en_o    = dmem_en_q;
    assign bus.dmem_wr_o    = dmem_wr_q;
    assign bus.dmem_addr_o  = dmem_addr_q;
    assign bus.dmem_wdata_o = dmem_wdata_q;

endmodule

// File: tb/tb_hv_core.sv
// tb_hv_core: self-checking bench for hv_core. A ROM table supplies the program; when an
// instruction is handed to the core, its expected next fetch address and any expected store
// are pushed to scoreboard queues, which are popped when the core fetches or writes.
// Register contents are observed by storing them to memory.
module tb_hv_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hv_if bus ();

    hv_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    localparam logic [6:0] OpI = 7'b0010011;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    typedef struct {
        logic [31:0] word;
        logic [31:0] nxt;      // expected next fetch address
        int          cyc;      // cycles from this fetch to the next, excluding fetch stalls
        bit          st;
        logic [31:0] st_addr;
        logic [31:0] st_data;
    } rom_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    function automatic rom_t rom(input logic [31:0] a);
        rom_t r;
        // Unlisted (wrong-path) slots clobber x5, which is later stored and checked for zero.
        r.word = enc_i(12'd9, 5'd0, 3'b000, 5'd5, OpI);
        r.nxt = a + 32'd4; r.cyc = 2; r.st = 1'b0; r.st_addr = '0; r.st_data = '0;
        case (a)
            32'h00: r.word = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OpI);
            32'h04: r.word = enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, OpI);
            32'h08: r.word = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
            32'h0C: begin r.word = enc_s(12'd0, 5'd3, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h0; r.st_data = 32'h7; end
            32'h10: begin r.word = enc_s(12'd4, 5'd2, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h4; r.st_data = 32'hFFFF_FFFE; end
            32'h14: r.word = enc_u(20'h12345, 5'd1, 7'b0110111);
            32'h18: r.word = enc_i(12'h678, 5'd1, 3'b000, 5'd1, OpI);
            32'h1C: begin r.word = enc_s(12'd8, 5'd1, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h8; r.st_data = 32'h1234_5678; end
            32'h20: begin r.word = enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011); r.cyc = 6; end
            32'h24: begin r.word = enc_s(12'd12, 5'd4, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'hC; r.st_data = 32'hCAFE_F00D; end
            32'h28: begin r.word = enc_b(13'd8, 5'd0, 5'd0, 3'b000); r.nxt = 32'h30; end
            32'h30: begin r.word = enc_j(21'd16, 5'd6); r.nxt = 32'h40; end
            32'h40: r.word = 32'hFFFF_FFFF;
            32'h44: begin r.word = enc_s(12'd16, 5'd6, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h10; r.st_data = 32'h34; end
            32'h48: begin r.word = enc_s(12'd20, 5'd5, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h14; r.st_data = 32'h0; end
            32'h4C: r.word = enc_i(12'hFF0, 5'd0, 3'b000, 5'd7, OpI);
            32'h50: r.word = enc_i({7'b0100000, 5'd2}, 5'd7, 3'b101, 5'd8, OpI);
            32'h54: r.word = enc_i(12'd28, 5'd7, 3'b101, 5'd9, OpI);
            32'h58: r.word = enc_r(7'b0, 5'd7, 5'd9, 3'b011, 5'd10);
            32'h5C: r.word = enc_r(7'b0, 5'd7, 5'd9, 3'b010, 5'd11);
            32'h60: begin r.word = enc_s(12'd24, 5'd8, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h18; r.st_data = 32'hFFFF_FFFC; end
            32'h64: begin r.word = enc_s(12'd28, 5'd9, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h1C; r.st_data = 32'hF; end
            32'h68: begin r.word = enc_s(12'd32, 5'd10, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h20; r.st_data = 32'h1; end
            32'h6C: begin r.word = enc_s(12'd36, 5'd11, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h24; r.st_data = 32'h0; end
            32'h70: begin r.word = enc_b(13'd8, 5'd0, 5'd7, 3'b100); r.nxt = 32'h78; end
            32'h78: r.word = enc_u(20'd0, 5'd12, 7'b0010111);
            32'h7C: begin r.word = enc_i(12'd17, 5'd12, 3'b000, 5'd13, 7'b1100111);
                          r.nxt = 32'h88; end
            32'h88: begin r.word = enc_s(12'd40, 5'd12, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h28; r.st_data = 32'h78; end
            32'h8C: begin r.word = enc_s(12'd44, 5'd13, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h2C; r.st_data = 32'h80; end
            // Misaligned effective address 0x33 must appear on the bus as 0x30.
            32'h90: begin r.word = enc_s(12'h033, 5'd5, 5'd0); r.cyc = 3; r.st = 1'b1;
                          r.st_addr = 32'h30; r.st_data = 32'h0; end
            32'h94: begin r.word = enc_b(13'd0, 5'd0, 5'd0, 3'b000); r.nxt = 32'h94; end
            default: ;
        endcase
        return r;
    endfunction

    logic [31:0] exp_pc_q[$];
    st_t         exp_st_q[$];

    initial begin
        rom_t e;
        st_t  s;
        int   cyc, last_acc, stalls, prev_cyc, rd_cnt, stall_left, halt_seen;
        bit   stop, done_stall;

        bus.instr_i            = '0;
        bus.instr_valid_i      = 1'b0;
        bus.dmem_rdata_i       = '0;
        bus.dmem_rdata_valid_i = 1'b0;

        #20;
        check32("rst_imem_en", {31'b0, bus.imem_en_o}, 32'd0);
        check32("rst_instr_addr", bus.instr_addr_o, 32'd0);
        check32("rst_dmem_en", {31'b0, bus.dmem_en_o}, 32'd0);
        check32("rst_dmem_wr", {31'b0, bus.dmem_wr_o}, 32'd0);
        check32("rst_dmem_addr", bus.dmem_addr_o, 32'd0);
        check32("rst_dmem_wdata", bus.dmem_wdata_o, 32'd0);
        #31 rst_n = 1'b1;
        #1 check32("idle_imem_en", {31'b0, bus.imem_en_o}, 32'd0);

        exp_pc_q.push_back(32'h0);
        cyc = 0; last_acc = -1; stalls = 0; prev_cyc = 0; rd_cnt = 0;
        stall_left = 0; halt_seen = 0; stop = 1'b0; done_stall = 1'b0;

        while (!stop && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            bus.instr_valid_i      = 1'b0;
            bus.dmem_rdata_valid_i = 1'b0;

            if (bus.imem_en_o) begin
                if (bus.instr_addr_o == 32'h4C && !done_stall) begin
                    stall_left = 3;
                    done_stall = 1'b1;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    stalls++;
                    check32("stall_addr", bus.instr_addr_o, 32'h4C);
                end else if (exp_pc_q.size() == 0) begin
                    stop = 1'b1;
                end else begin
                    check32("fetch_addr", bus.instr_addr_o, exp_pc_q.pop_front());
                    if (last_acc >= 0)
                        check32("fetch_cycles", cyc - last_acc - stalls, prev_cyc);
                    e = rom(bus.instr_addr_o);
                    bus.instr_i       = e.word;
                    bus.instr_valid_i = 1'b1;
                    if (e.st) exp_st_q.push_back({e.st_addr, e.st_data});
                    if (bus.instr_addr_o == 32'h94) halt_seen++;
                    if (halt_seen < 2) exp_pc_q.push_back(e.nxt);
                    last_acc = cyc;
                    stalls   = 0;
                    prev_cyc = e.cyc;
                end
            end

            if (bus.dmem_en_o && bus.dmem_wr_o) begin
                check32("store_pending", {31'b0, exp_st_q.size() > 0}, 32'd1);
                if (exp_st_q.size() > 0) begin
                    s = exp_st_q.pop_front();
                    check32("store_addr", bus.dmem_addr_o, s.addr);
                    check32("store_data", bus.dmem_wdata_o, s.data);
                end
            end

            if (bus.dmem_en_o && !bus.dmem_wr_o) begin
                rd_cnt++;
                check32("load_addr", bus.dmem_addr_o, 32'h8);
                // MEM cycle plus two LWAIT cycles without data, then data.
                if (rd_cnt == 4) begin
                    bus.dmem_rdata_i       = 32'hCAFE_F00D;
                    bus.dmem_rdata_valid_i = 1'b1;
                end
            end
        end

        check32("program_done", {31'b0, stop}, 32'd1);
        check32("stores_left", 32'(exp_st_q.size()), 32'd0);

        // Core is stalled in FETCH at the halt loop; reset must drop outputs at once.
        check32("pre_reset_imem_en", {31'b0, bus.imem_en_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check32("abort_imem_en", {31'b0, bus.imem_en_o}, 32'd0);
        check32("abort_instr_addr", bus.instr_addr_o, 32'd0);
        check32("abort_dmem_wdata", bus.dmem_wdata_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hv_core.md
Name: hv_core

Overview:
- Minimal 32-bit multicycle RISC core implementing an RV32I subset.
- Has a read-only instruction port and a word-wide data memory port, each with a valid handshake.
- Sits between an instruction ROM and a data RAM at the top of the small SoC.
- Executes one instruction at a time: there is no pipeline and no hazard logic.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_i  in  32  instruction word returned for instr_addr_o.
- instr_valid_i  in  1  instr_i valid this cycle.
- instr_addr_o  out  32  byte address of the fetch (equals pc).
- imem_en_o  out  1  instruction fetch request.
- dmem_rdata_i  in  32  load data.
- dmem_rdata_valid_i  in  1  dmem_rdata_i valid this cycle.
- dmem_addr_o  out  32  data byte address, word aligned (bits 1:0 forced to 0).
- dmem_wdata_o  out  32  store data.
- dmem_en_o  out  1  data access request.
- dmem_wr_o  out  1  1 = write, 0 = read; meaningful only while dmem_en_o=1.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, all 32 registers=0, IR=0. All outputs are 0 while rst_n=0.
- IDLE -> FETCH on the first clock edge after reset release.
- FETCH:
  - imem_en_o=1, instr_addr_o=pc.
  - On an edge with instr_valid_i=1: IR<=instr_i, go to EXEC. Otherwise stay in FETCH (stall).
- EXEC:
  - Decode IR; read rs1 and rs2 (x0 always reads 0; writes to x0 are discarded).
  - ALU and branch instructions: write rd, update pc, go to FETCH. This gives 2 cycles per instruction with zero stalls.
  - LW/SW: compute addr = rs1 + sign-extended imm, latch it, go to MEM.
- MEM:
  - dmem_en_o=1, dmem_addr_o=addr & ~3.
  - SW: dmem_wr_o=1, dmem_wdata_o=rs2. Lasts exactly one cycle, then pc+=4 and go to FETCH (3 cycles total).
  - LW: dmem_wr_o=0, go to LWAIT.
- LWAIT:
  - Keep dmem_en_o=1, dmem_wr_o=0 and the same address.
  - On an edge with dmem_rdata_valid_i=1: rd<=dmem_rdata_i, pc+=4, go to FETCH (≥4 cycles total).
  - This state makes the core compatible with synchronous-read RAM.
- Outputs outside their active states: imem_en_o=0, dmem_en_o=0, dmem_wr_o=0. Address and data outputs hold their last values.
- Supported instructions (standard RV32I encodings):
  - LUI, AUIPC, JAL, JALR (target bit 0 cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Any other encoding, including byte/halfword loads and stores, executes as a NOP: pc+=4, no register write.
- Arithmetic: all 32-bit, wrap-around with no flags. Shift amount = low 5 bits. Immediates are sign-extended per RV32I.
- Branch and jump targets: pc + imm, wrap modulo 2^32. JAL/JALR write pc+4 to rd.
- Reset asserted mid-operation (e.g. in LWAIT) aborts immediately; outputs drop to 0 asynchronously.

Decomposition:
- Package hv_pkg: opcode/funct3/funct7 constants, state enum (IDLE, FETCH, EXEC, MEM, LWAIT), ALU operation enum.
- One sub-module, hv_alu: combinational, inputs a, b, op; output result. It also provides the branch compare result.
- Register file and FSM live in hv_core.

Test Plan:
- Reset then fetch: rst_n low 51 ns, then high. Cycle 1: imem_en_o=0. Next cycle: imem_en_o=1, instr_addr_o=0x0.
- ALU: ROM at 0x0 = ADDI x1,x0,5; at 0x4 = ADDI x2,x1,-7; at 0x8 = SUB x3,x1,x2. Require fetch addresses 0,4,8 every 2 cycles; x3=7, x2=0xFFFF_FFFE.
- Store: x1=0x12345678, then SW x1,8(x0). Require exactly one cycle with dmem_en_o=1, dmem_wr_o=1, dmem_addr_o=0x8, dmem_wdata_o=0x12345678.
- Load with stall: LW x4,8(x0) with dmem_rdata_valid_i held low for 2 cycles, then high with data 0xCAFEF00D. Require address held at 0x8 throughout; x4=0xCAFEF00D; next fetch at pc+4.
- Control flow:
  - BEQ x0,x0,-8 at 0x10: next fetch address is 0x8.
  - JAL x1,+16 at 0x20: x1=0x24, next fetch address is 0x30.
  - Illegal word 0xFFFFFFFF: treated as NOP, pc+=4.
- instr_valid_i low for 3 cycles during FETCH: core stays in FETCH with the address stable; no register or pc change.
